switch_control: RTL and testbench

- Per-router connection controller for the Phoenix mesh router.
- Arbitrates round-robin among the NPORT input buffers that hold a pending header flit.
- Computes the XY output port for the winner and grants the connection only if that output is free.
- Drives the crossbar select and enable per output, and releases each connection when the owning input reports the packet tail sent.

---
 rtl/switch_control_pkg.sv | 33 +++
 rtl/switch_control_if.sv | 24 ++
 rtl/switch_control_rr_arbiter.sv | 24 ++
 rtl/switch_control.sv | 130 +++++++++++++
 tb/tb_switch_control.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/switch_control_pkg.sv
// Shared definitions for the Phoenix router connection controller:
// flit geometry, port indices and FSM state encodings.
package switch_control_pkg;

    localparam int TAM_FLIT   = 16;
    localparam int METADEFLIT = 8;
    localparam int NPORT      = 5;
    localparam int PORT_IDX_W = 3;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    localparam port_idx_t EAST  = 3'd0;
    localparam port_idx_t WEST  = 3'd1;
    localparam port_idx_t NORTH = 3'd2;
    localparam port_idx_t SOUTH = 3'd3;
    localparam port_idx_t LOCAL = 3'd4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_ROUTE = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_GRANT = 3'd4;

    // Port index base+offset, wrapping modulo NPORT (4 -> 0).
    function automatic port_idx_t wrap_idx(port_idx_t base, int offset);
        return port_idx_t'((int'(base) + offset) % NPORT);
    endfunction

    function automatic logic [NPORT-1:0] port_onehot(port_idx_t p);
        return NPORT'(1) << p;
    endfunction

endpackage

// File: rtl/switch_control_if.sv
// Handshake and crossbar-control bundle between the input buffers,
// the crossbar and the connection controller.
interface switch_control_if;
    import switch_control_pkg::*;

    logic [NPORT-1:0]            h;
    logic [NPORT*TAM_FLIT-1:0]   header_in;
    logic [NPORT-1:0]            pkt_done;
    logic [NPORT-1:0]            ack_h;
    logic [NPORT*PORT_IDX_W-1:0] out_sel;
    logic [NPORT-1:0]            out_en;
    logic                        busy;

    modport master (
        output h, header_in, pkt_done,
        input  ack_h, out_sel, out_en, busy
    );

    modport slave (
        input  h, header_in, pkt_done,
        output ack_h, out_sel, out_en, busy
    );

endinterface

// File: rtl/switch_control_rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr,
// searching ptr+1, ptr+2, ... modulo NPORT.
module switch_control_rr_arbiter
    import switch_control_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  port_idx_t        ptr,
    output port_idx_t        grant,
    output logic             valid
);

    always_comb begin
        // NOTE: defaults first, so every path through the loop assigns both outputs (no latch).
        grant = '0;
        valid = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            if (!valid && req[wrap_idx(ptr, k)]) begin
                grant = wrap_idx(ptr, k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_control.sv
// Per-router connection controller: round-robin header arbitration, XY routing,
// output-free check, crossbar grant, and per-input release on packet tail.
module switch_control
    import switch_control_pkg::*;
#(
    parameter logic [TAM_FLIT-1:0] address = 16'h0101
) (
    input  logic             clock,
    input  logic             reset,
    switch_control_if.slave  bus
);

    logic [2:0]                      state;
    port_idx_t                       sel;
    port_idx_t                       dir;
    port_idx_t                       rr_ptr;
    logic [TAM_FLIT-1:0]             hdr_q;
    logic [NPORT-1:0]                ack_q;
    logic [NPORT-1:0]                out_en_q;
    logic [NPORT-1:0][PORT_IDX_W-1:0] out_sel_q;
    port_idx_t                       owner [NPORT];
    logic [NPORT-1:0]                owner_valid;

    logic [NPORT-1:0][TAM_FLIT-1:0]  hdr_arr;
    port_idx_t                       arb_grant;
    logic                            arb_valid;
    port_idx_t                       route_dir;
    logic [METADEFLIT-1:0]           dx, dy, lx, ly;

    assign hdr_arr = bus.header_in;

    switch_control_rr_arbiter u_rr_arbiter (
        .req   (bus.h),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign dx = hdr_q[TAM_FLIT-1:METADEFLIT];
    assign dy = hdr_q[METADEFLIT-1:0];
    assign lx = address[TAM_FLIT-1:METADEFLIT];
    assign ly = address[METADEFLIT-1:0];

    // XY routing: resolve X first, then Y, else deliver locally.
    always_comb begin
        route_dir = LOCAL;
        if (dx > lx)
            route_dir = EAST;
        else if (dx < lx)
            route_dir = WEST;
        else if (dy < ly)
            route_dir = SOUTH;
        else if (dy > ly)
            route_dir = NORTH;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            sel         <= '0;
            dir         <= '0;
            rr_ptr      <= LOCAL;
            hdr_q       <= '0;
            ack_q       <= '0;
            out_en_q    <= '0;
            out_sel_q   <= '0;
            owner_valid <= '0;
            // NOTE: the owner table steers out_en on release, so it is cleared with the rest of the state.
            for (int i = 0; i < NPORT; i++)
                owner[i] <= '0;
        end else begin
            ack_q <= '0;

            for (int i = 0; i < NPORT; i++) begin
                if (bus.pkt_done[i] && owner_valid[i]) begin
                    out_en_q[owner[i]] <= 1'b0;
                    owner_valid[i]     <= 1'b0;
                end
            end

            // NOTE: release is written above the grant; with non-blocking assignments the later grant write wins.
            case (state)
                S_IDLE: begin
                    if (|bus.h)
                        state <= S_ARB;
                end
                S_ARB: begin
                    if (arb_valid) begin
                        sel   <= arb_grant;
                        hdr_q <= hdr_arr[arb_grant];
                        state <= S_ROUTE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ROUTE: begin
                    if (!bus.h[sel]) begin
                        state <= S_IDLE;
                    end else begin
                        dir   <= route_dir;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!out_en_q[dir]) begin
                        ack_q <= port_onehot(sel);
                        state <= S_GRANT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    out_en_q[dir]    <= 1'b1;
                    out_sel_q[dir]   <= sel;
                    owner[sel]       <= dir;
                    owner_valid[sel] <= 1'b1;
                    rr_ptr           <= sel;
                    state            <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack_h   = ack_q;
    assign bus.out_en  = out_en_q;
    assign bus.out_sel = out_sel_q;
    assign bus.busy    = (state != S_IDLE);

endmodule

// File: tb/tb_switch_control.sv
// Directed self-checking bench for switch_control at address 16'h0101:
// latency, XY directions, round-robin alternation, blocking/retry, reset, release.
module tb_switch_control;
    import switch_control_pkg::*;

    logic clock;
    logic reset;
    switch_control_if bus ();

    int tests = 0;
    int fails = 0;

    logic [NPORT-1:0] got;
    int               cyc;
    logic             seen_ack;
    logic             seen_busy;

    logic [15:0] dir_hdr [4];
    logic [4:0]  dir_en  [4];
    int          dir_idx [4];

    switch_control #(.address(16'h0101)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_hdr(input int p, input logic [15:0] v);
        bus.header_in[p*TAM_FLIT +: TAM_FLIT] = v;
    endtask

    task automatic pulse_done(input logic [4:0] m);
        bus.pkt_done = m;
        @(negedge clock);
        bus.pkt_done = '0;
    endtask

    // Waits (bounded) for a non-zero ack_h; got stays 0 on timeout.
    task automatic wait_ack(output logic [4:0] g, output int c);
        g = '0;
        c = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (bus.ack_h != '0) begin
                g = bus.ack_h;
                c = k;
                break;
            end
        end
    endtask

    function automatic logic [2:0] sel_of(input int p);
        return bus.out_sel[p*PORT_IDX_W +: PORT_IDX_W];
    endfunction

    initial begin
        dir_hdr = '{16'h0001, 16'h0100, 16'h0102, 16'h0101};
        dir_en  = '{5'b00010, 5'b01000, 5'b00100, 5'b10000};
        dir_idx = '{1, 3, 2, 4};

        bus.h         = '0;
        bus.header_in = '0;
        bus.pkt_done  = '0;
        reset         = 1'b1;
        step(2);
        check("reset_out_en",  32'(bus.out_en),  'h0);
        check("reset_ack_h",   32'(bus.ack_h),   'h0);
        check("reset_busy",    32'(bus.busy),    'h0);
        check("reset_out_sel", 32'(bus.out_sel), 'h0);
        reset = 1'b0;
        step(1);

        // LOCAL -> EAST, exact 4-cycle grant latency
        set_hdr(4, 16'h0201);
        bus.h = 5'b10000;
        wait_ack(got, cyc);
        check("t1_ack",     32'(got), 'b10000);
        check("t1_latency", 32'(cyc), 4);
        bus.h = '0;
        step(1);
        check("t1_out_en",   32'(bus.out_en), 'b00001);
        check("t1_out_sel",  32'(sel_of(0)),  4);
        check("t1_busy",     32'(bus.busy),   0);
        check("t1_ack_drop", 32'(bus.ack_h),  0);
        pulse_done(5'b10000);
        check("t1_release", 32'(bus.out_en), 'h0);

        // XY directions from LOCAL: WEST, SOUTH, NORTH, LOCAL
        for (int j = 0; j < 4; j++) begin
            set_hdr(4, dir_hdr[j]);
            bus.h = 5'b10000;
            wait_ack(got, cyc);
            check($sformatf("t2_ack_%0d", j), 32'(got), 'b10000);
            bus.h = '0;
            step(1);
            check($sformatf("t2_out_en_%0d", j),  32'(bus.out_en), 32'(dir_en[j]));
            check($sformatf("t2_out_sel_%0d", j), 32'(sel_of(dir_idx[j])), 4);
            pulse_done(5'b10000);
            check($sformatf("t2_release_%0d", j), 32'(bus.out_en), 'h0);
        end

        // Round-robin alternation between EAST and WEST, both routed LOCAL
        set_hdr(0, 16'h0101);
        set_hdr(1, 16'h0101);
        bus.h = 5'b00011;
        wait_ack(got, cyc);
        check("t3_first_east", 32'(got), 'b00001);
        bus.h = 5'b00010;
        step(1);
        check("t3_en_a",  32'(bus.out_en), 'b10000);
        check("t3_sel_a", 32'(sel_of(4)),  0);
        bus.h = 5'b00011;
        pulse_done(5'b00001);
        wait_ack(got, cyc);
        check("t3_then_west", 32'(got), 'b00010);
        bus.h = 5'b00001;
        step(1);
        check("t3_sel_b", 32'(sel_of(4)), 1);
        bus.h = 5'b00011;
        pulse_done(5'b00010);
        wait_ack(got, cyc);
        check("t3_then_east", 32'(got), 'b00001);
        bus.h = 5'b00010;
        step(1);
        check("t3_sel_c", 32'(sel_of(4)), 0);
        pulse_done(5'b00001);
        wait_ack(got, cyc);
        check("t3_then_west2", 32'(got), 'b00010);
        bus.h = '0;
        step(1);
        check("t3_sel_d", 32'(sel_of(4)), 1);
        pulse_done(5'b00010);
        check("t3_release", 32'(bus.out_en), 'h0);

        // Blocked output: WEST retries while EAST owns LOCAL
        bus.h = 5'b00001;
        wait_ack(got, cyc);
        check("t4_east_ack", 32'(got), 'b00001);
        bus.h = '0;
        step(1);
        check("t4_en_held", 32'(bus.out_en), 'b10000);
        bus.h     = 5'b00010;
        seen_ack  = 1'b0;
        seen_busy = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            seen_ack  = seen_ack  | (|bus.ack_h);
            seen_busy = seen_busy | bus.busy;
        end
        check("t4_no_ack",    32'(seen_ack),  0);
        check("t4_busy_seen", 32'(seen_busy), 1);
        pulse_done(5'b00100);
        check("t6_idle_release", 32'(bus.out_en), 'b10000);
        pulse_done(5'b00001);
        wait_ack(got, cyc);
        check("t4_west_ack",     32'(got),      'b00010);
        check("t4_retry_window", 32'(cyc <= 4), 1);
        bus.h = '0;
        step(1);
        check("t4_en",  32'(bus.out_en), 'b10000);
        check("t4_sel", 32'(sel_of(4)),  1);
        pulse_done(5'b00010);
        check("t4_release", 32'(bus.out_en), 'h0);

        // Reset during S_ROUTE with NORTH output held by WEST (rr_ptr = WEST)
        set_hdr(1, 16'h0102);
        bus.h = 5'b00010;
        wait_ack(got, cyc);
        check("t5_setup_ack", 32'(got), 'b00010);
        bus.h = '0;
        step(1);
        check("t5_setup_en", 32'(bus.out_en), 'b00100);
        set_hdr(0, 16'h0101);
        set_hdr(2, 16'h0201);
        bus.h = 5'b00001;
        step(2);
        check("t5_busy_route", 32'(bus.busy), 1);
        reset = 1'b1;
        bus.h = 5'b00101;
        step(1);
        check("t5_rst_out_en", 32'(bus.out_en), 'h0);
        check("t5_rst_ack",    32'(bus.ack_h),  'h0);
        check("t5_rst_busy",   32'(bus.busy),   0);
        reset = 1'b0;
        wait_ack(got, cyc);
        check("t5_first_east", 32'(got), 'b00001);
        bus.h = 5'b00100;
        wait_ack(got, cyc);
        check("t5_then_north", 32'(got), 'b00100);
        bus.h = '0;
        step(1);
        check("t5_en_two", 32'(bus.out_en), 'b10001);
        pulse_done(5'b00101);
        check("t5_multi_release", 32'(bus.out_en), 'h0);
        check("t5_sel_held",      32'(sel_of(0)),  2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
